// File: rtl/imm_gen_pipe_if.sv
// Stream interface for imm_gen_pipe.
//   Upstream (instruction) side : in_valid, in_ready, in_instr[31:0], in_pc[XLEN-1:0]
//   Downstream (result) side    : out_valid, out_ready, out_imm, out_target,
//                                 out_fmt[2:0], out_illegal
// The slave modport is the decoder's view; the master modport is the
// environment's view (drives instructions, consumes results).
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: single-stage pipelined RV32I/RV64I immediate generator.
// Decodes the immediate and format of the presented instruction, computes
// the PC-relative target pc + imm, and registers the result behind a
// valid/ready handshake with flush. A saturating counter records how many
// accepted (unflushed) instructions had an undecodable opcode.
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   bus         imm_gen_pipe_if.slave (instruction in, result out)
//   flush       kills the held result and any instruction accepted this cycle
//   cnt_clr     clears illegal_cnt (wins over a same-cycle increment)
//   illegal_cnt saturating illegal-opcode count
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_gen_pipe_if.slave        bus,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] illegal_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("imm_gen_pipe: CNT_WIDTH must be >= 1");
  end

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- stage p0: combinational decode of the presented instruction ----
  logic [6:0]             opcode_p0;
  logic signed [11:0]     imm_i_p0;
  logic signed [11:0]     imm_s_p0;
  logic signed [12:0]     imm_b_p0;
  logic signed [31:0]     imm_u_p0;
  logic signed [20:0]     imm_j_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [XLEN-1:0]        target_p0;
  logic [2:0]             fmt_p0;
  logic                   illegal_p0;
  logic                   accept_p0;

  // Narrow signed fields; the XLEN'() casts below sign-extend from instr[31].
  assign opcode_p0 = bus.in_instr[6:0];
  assign imm_i_p0  = bus.in_instr[31:20];
  assign imm_s_p0  = {bus.in_instr[31:25], bus.in_instr[11:7]};
  assign imm_b_p0  = {bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25],
                      bus.in_instr[11:8], 1'b0};
  assign imm_u_p0  = {bus.in_instr[31:12], 12'b0};
  assign imm_j_p0  = {bus.in_instr[31], bus.in_instr[19:12], bus.in_instr[20],
                      bus.in_instr[30:21], 1'b0};

  always_comb begin
    fmt_p0     = FMT_NONE;
    illegal_p0 = 1'b0;
    imm_p0     = '0;
    case (opcode_p0)
      OP_OPIMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
        fmt_p0 = FMT_I;
        imm_p0 = XLEN'(imm_i_p0);
      end
      OP_STORE: begin
        fmt_p0 = FMT_S;
        imm_p0 = XLEN'(imm_s_p0);
      end
      OP_BRANCH: begin
        fmt_p0 = FMT_B;
        imm_p0 = XLEN'(imm_b_p0);
      end
      OP_LUI, OP_AUIPC: begin
        fmt_p0 = FMT_U;
        imm_p0 = XLEN'(imm_u_p0);
      end
      OP_JAL: begin
        fmt_p0 = FMT_J;
        imm_p0 = XLEN'(imm_j_p0);
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  // imm is zero for undecodable opcodes, so the target degenerates to pc.
  assign target_p0 = bus.in_pc + $unsigned(imm_p0);

  // ---- stage p1: result registers and handshake ----
  logic                   vld_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [XLEN-1:0]        target_p1;
  logic [2:0]             fmt_p1;
  logic                   illegal_p1;
  logic [CNT_WIDTH-1:0]   cnt_p1;

  // rst_n gates in_ready so nothing is accepted while reset is held.
  assign bus.in_ready = rst_n & (~vld_p1 | bus.out_ready);
  assign accept_p0    = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      imm_p1     <= '0;
      target_p1  <= '0;
      fmt_p1     <= FMT_NONE;
      illegal_p1 <= 1'b0;
      cnt_p1     <= '0;
    end else begin
      if (flush)              vld_p1 <= 1'b0;
      else if (accept_p0)     vld_p1 <= 1'b1;
      else if (bus.out_ready) vld_p1 <= 1'b0;

      if (accept_p0 && !flush) begin
        imm_p1     <= imm_p0;
        target_p1  <= target_p0;
        fmt_p1     <= fmt_p0;
        illegal_p1 <= illegal_p0;
      end

      if (cnt_clr)                                 cnt_p1 <= '0;
      else if (accept_p0 && !flush && illegal_p0)  cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_imm     = imm_p1;
  assign bus.out_target  = target_p1;
  assign bus.out_fmt     = fmt_p1;
  assign bus.out_illegal = illegal_p1;
  assign illegal_cnt     = cnt_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: an XLEN=32 instance driven cycle by
// cycle against a reference model plus scoreboard, and an XLEN=64 instance
// exercised with a few directed instructions.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  logic       flush32, cnt_clr32, flush64, cnt_clr64;
  logic [7:0] illegal_cnt32, illegal_cnt64;

  imm_gen_pipe #(.XLEN(32), .CNT_WIDTH(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32),
    .flush(flush32), .cnt_clr(cnt_clr32), .illegal_cnt(illegal_cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_WIDTH(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64),
    .flush(flush64), .cnt_clr(cnt_clr64), .illegal_cnt(illegal_cnt64)
  );

  typedef struct {
    logic [31:0] imm;
    logic [31:0] target;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t       sb_q[$];
  logic       m_vld;
  logic [7:0] m_cnt;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode, always produced at 64 bits; 32-bit users truncate.
  function automatic void model(input logic [31:0] ins, output logic [63:0] imm,
                                output logic [2:0] fmt, output logic ill);
    logic [6:0] op;
    op  = ins[6:0];
    imm = 64'd0;
    fmt = 3'd0;
    ill = 1'b0;
    case (op)
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
        fmt = 3'd1; imm = {{52{ins[31]}}, ins[31:20]};
      end
      7'h23: begin
        fmt = 3'd2; imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'h63: begin
        fmt = 3'd3; imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h37, 7'h17: begin
        fmt = 3'd4; imm = {{32{ins[31]}}, ins[31:12], 12'h000};
      end
      7'h6F: begin
        fmt = 3'd5; imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  // One clock cycle on the 32-bit instance: drive inputs, check the
  // registered outputs against the model, then advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic clr, input logic rst);
    logic        exp_rdy, acc, ill;
    logic [63:0] imm;
    logic [2:0]  fmt;
    exp_t        e;
    @(negedge clk);
    rst_n           = rst;
    bus32.in_valid  = v;
    bus32.in_instr  = ins;
    bus32.in_pc     = pc;
    bus32.out_ready = ordy;
    flush32         = fl;
    cnt_clr32       = clr;
    #1;
    exp_rdy = rst & (!m_vld | ordy);
    chk("in_ready", 64'(bus32.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus32.out_valid), 64'(m_vld));
    chk("illegal_cnt", 64'(illegal_cnt32), 64'(m_cnt));
    if (m_vld) begin
      chk("sb_depth", 64'(sb_q.size()), 64'd1);
      if (sb_q.size() != 0) begin
        chk("out_imm", 64'(bus32.out_imm), 64'(sb_q[0].imm));
        chk("out_target", 64'(bus32.out_target), 64'(sb_q[0].target));
        chk("out_fmt", 64'(bus32.out_fmt), 64'(sb_q[0].fmt));
        chk("out_illegal", 64'(bus32.out_illegal), 64'(sb_q[0].ill));
      end
    end
    model(ins, imm, fmt, ill);
    acc = v & exp_rdy;
    if (!rst) begin
      m_vld = 1'b0;
      m_cnt = 8'd0;
      sb_q.delete();
    end else begin
      if (m_vld && ordy && sb_q.size() != 0) void'(sb_q.pop_front());
      if (fl) begin
        sb_q.delete();
        m_vld = 1'b0;
      end else if (acc) begin
        e.imm    = imm[31:0];
        e.target = pc + imm[31:0];
        e.fmt    = fmt;
        e.ill    = ill;
        sb_q.push_back(e);
        m_vld = 1'b1;
      end else if (ordy) begin
        m_vld = 1'b0;
      end
      if (clr)                                 m_cnt = 8'd0;
      else if (acc && !fl && ill && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
  endtask

  // Called right after a step with rst=0: check state after the reset edge.
  task automatic check_zero();
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst_out_imm", 64'(bus32.out_imm), 64'd0);
    chk("rst_out_target", 64'(bus32.out_target), 64'd0);
    chk("rst_out_fmt", 64'(bus32.out_fmt), 64'd0);
    chk("rst_out_illegal", 64'(bus32.out_illegal), 64'd0);
    chk("rst_illegal_cnt", 64'(illegal_cnt32), 64'd0);
    chk("rst_in_ready", 64'(bus32.in_ready), 64'd0);
  endtask

  task automatic step64(input logic [31:0] ins, input logic [63:0] pc);
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    @(negedge clk);
    bus64.in_valid = 1'b1;
    bus64.in_instr = ins;
    bus64.in_pc    = pc;
    @(negedge clk);
    bus64.in_valid = 1'b0;
    #1;
    model(ins, imm, fmt, ill);
    chk("x64_out_valid", 64'(bus64.out_valid), 64'd1);
    chk("x64_out_imm", bus64.out_imm, imm);
    chk("x64_out_target", bus64.out_target, pc + imm);
    chk("x64_out_fmt", 64'(bus64.out_fmt), 64'(fmt));
    chk("x64_out_illegal", 64'(bus64.out_illegal), 64'(ill));
  endtask

  localparam logic [31:0] ADDI = 32'hFFF00093;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] JAL  = 32'h0010006F;
  localparam logic [31:0] LUI  = 32'h123452B7;
  localparam logic [31:0] SW   = 32'h00112623;
  localparam logic [31:0] BAD  = 32'h00000000;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_pc = '0; bus32.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;
    flush32 = 1'b0; cnt_clr32 = 1'b0; flush64 = 1'b0; cnt_clr64 = 1'b0;
    m_vld = 1'b0;
    m_cnt = 8'd0;
    repeat (2) @(posedge clk);

    // Directed decode stream, downstream always ready
    step(1, ADDI, 32'h0,    1, 0, 0, 1);
    step(1, BEQ,  32'h100,  1, 0, 0, 1);
    step(1, JAL,  32'h1000, 1, 0, 0, 1);
    step(1, LUI,  32'h2000, 1, 0, 0, 1);
    step(1, SW,   32'h40,   1, 0, 0, 1);
    step(0, BAD,  32'h0,    1, 0, 0, 1);

    // Backpressure: ADDI held for 3 cycles while BEQ waits
    step(1, ADDI, 32'h0,   1, 0, 0, 1);
    step(1, BEQ,  32'h100, 0, 0, 0, 1);
    step(1, BEQ,  32'h100, 0, 0, 0, 1);
    step(1, BEQ,  32'h100, 0, 0, 0, 1);
    step(1, BEQ,  32'h100, 1, 0, 0, 1);
    step(0, BAD,  32'h0,   1, 0, 0, 1);

    // Flush while holding, then flush of an incoming instruction
    step(1, ADDI, 32'h4,   1, 0, 0, 1);
    step(1, BEQ,  32'h100, 0, 0, 0, 1);
    step(1, BEQ,  32'h100, 0, 1, 0, 1);
    step(0, BAD,  32'h0,   1, 0, 0, 1);
    step(1, JAL,  32'h80,  1, 1, 0, 1);
    step(0, BAD,  32'h0,   1, 0, 0, 1);

    // Counter: clear vs. simultaneous illegal, flushed illegal, saturation
    step(1, BAD, 32'h0, 1, 0, 0, 1);
    step(1, BAD, 32'h4, 1, 0, 1, 1);
    step(1, BAD, 32'h8, 1, 1, 0, 1);
    step(1, BAD, 32'hC, 1, 0, 0, 1);
    step(0, BAD, 32'h0, 1, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(1, BAD, 32'(i * 4), 1, 0, 0, 1);
    step(0, BAD, 32'h0, 1, 0, 0, 1);
    step(0, BAD, 32'h0, 1, 0, 0, 1);

    // Randomised mix of stalls, flushes and clears
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), rand_instr(), $urandom,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 15) == 0), 1'b1);
    step(0, BAD, 32'h0, 1, 0, 0, 1);

    // Reset while a result is held
    step(1, ADDI, 32'h10, 1, 0, 0, 1);
    step(1, BEQ,  32'h20, 0, 0, 0, 0);
    check_zero();
    step(0, BAD,  32'h0,  1, 0, 0, 1);
    step(1, LUI,  32'h0,  1, 0, 0, 1);
    step(0, BAD,  32'h0,  1, 0, 0, 1);

    // XLEN=64 instance
    step64(32'h800002B7, 64'h0);
    step64(ADDI,         64'h0);
    step64(BEQ,          64'h0000_0001_0000_0000);
    step64(32'h8000006F, 64'h0000_0000_0010_0000);
    step64(32'h00001017, 64'hFFFF_FFFF_FFFF_F000);
    step64(SW,           64'h8000_0000_0000_0000);
    chk("x64_illegal_cnt", 64'(illegal_cnt64), 64'd0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised successor to the combinational immediate generator in the decode stage.
- Decodes the immediate for all RV32I/RV64I base formats (I, S, B, U, J) and reports the format code.
- Computes the PC-relative target, `pc + imm`.
- Registers its results behind a valid/ready handshake with flush support, and keeps a saturating count of undecodable opcodes for debug.

Parameters:
- XLEN, 32, datapath width for pc/imm/target; legal values are 32 and 64 only (elaboration error otherwise).
- CNT_WIDTH, 8, width of the illegal-opcode counter (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  block can accept an instruction this cycle.
- in_instr  input  32  instruction word; opcode is taken from in_instr[6:0] internally.
- in_pc  input  XLEN  PC of in_instr.
- flush  input  1  kill the in-flight and incoming instruction.
- cnt_clr  input  1  clear illegal_cnt.
- out_valid  output  1  output registers hold a valid result.
- out_ready  input  1  downstream accepts the result.
- out_imm  output  XLEN  sign-extended immediate.
- out_target  output  XLEN  in_pc + imm, modulo 2^XLEN.
- out_fmt  output  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_illegal  output  1  opcode not in the decode list.
- illegal_cnt  output  CNT_WIDTH  saturating count of accepted illegal opcodes.

Behaviour:
- Format decode by opcode:
  - I: 0010011, 0000011, 1100111, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode: fmt=NONE, imm=0, illegal=1.
- Immediate assembly (all formats sign-extend from instr[31] to XLEN):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}; for XLEN=64, bits 63:32 are copies of instr[31].
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Target = in_pc + imm, computed for every format, truncated to XLEN. For fmt=NONE the target is in_pc.
- Handshake:
  - in_ready = rst_n & (!out_valid | out_ready), combinational.
  - Accept occurs when in_valid & in_ready.
  - Latency is exactly 1 cycle: an instruction accepted in cycle N is visible on the outputs in cycle N+1.
- Output hold: while out_valid & !out_ready, out_imm/out_target/out_fmt/out_illegal stay stable and no new input is accepted.
- Drain: out_ready & !accept drives out_valid to 0 on the next cycle. Data registers may hold stale values; only out_valid is meaningful.
- Flush:
  - Flush wins over everything except reset.
  - On the next cycle out_valid=0.
  - An instruction accepted in the flush cycle is discarded and is not counted.
  - in_ready is unaffected by flush.
- Counter:
  - Increments by 1 when an accepted, unflushed instruction is illegal.
  - Saturates at 2^CNT_WIDTH-1.
  - cnt_clr has priority over an increment in the same cycle (result 0).
  - The counter is independent of out_ready.
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, out_imm=0, out_target=0, out_fmt=0, out_illegal=0, illegal_cnt=0.
  - in_ready=0 while rst_n is low.
  - Reset mid-transfer drops the held result without a handshake.

Test Plan:
- ADDI 0xFFF00093, pc 0x0, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, target=0xFFFFFFFF, illegal=0.
- BEQ 0xFE000EE3, pc 0x100 -> imm=0xFFFFFFFC, fmt=3, target=0x000000FC.
- JAL 0x0010006F, pc 0x1000 -> imm=0x800, fmt=5, target=0x1800.
- LUI 0x123452B7 -> imm=0x12345000, fmt=4. With XLEN=64, LUI 0x800002B7 -> imm=0xFFFFFFFF80000000.
- Backpressure: accept ADDI, hold out_ready=0 for 3 cycles with BEQ presented.
  - Required: outputs stable at the ADDI result and in_ready=0.
  - When out_ready=1, BEQ is accepted that cycle and its result appears the next cycle.
  - Flush while holding -> out_valid=0 the next cycle.
- Counter, CNT_WIDTH=8:
  - 300 accepted instructions 0x00000000 -> illegal_cnt=255, out_fmt=0, imm=0.
  - Illegal accepted with flush=1 -> count unchanged.
  - cnt_clr with a simultaneous illegal accept -> illegal_cnt=0.
  - rst_n low mid-stream -> all outputs 0 on the next cycle.
